hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB). Decides each cycle whether IF/ID hold, flush, or advance.
- Resolves RAW hazards by stalling (no forwarding path exists) and squashes wrong-path instructions on taken branches and jumps.
- Replaces the delay-based terminate logic with a clocked drain FSM that asserts halt once in-flight instructions retire.
- Keeps saturating stall and flush counters for test benches.

Parameters:
- DRAIN_CYCLES, 4, cycles after halt acceptance before halt_out asserts; range 1..15.
- CNT_W, 32, width of performance counters.

Ports:
- CLK  in  1  clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- rs_addr_D  in  5  rs field of instruction in ID.
- rt_addr_D  in  5  rt field of instruction in ID.
- use_rs_D  in  1  ID instruction reads rs.
- use_rt_D  in  1  ID instruction reads rt.
- JumpD  in  1  ID instruction is j/jal/jr.
- halt_D  in  1  ID instruction equals 32'hffffffff.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  stage writes the register file.
- write_reg_E, write_reg_M, write_reg_W  in  5 each  destination register per stage.
- branch_taken_E  in  1  branch in EX resolved taken this cycle.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID register.
- FlushD  out  1  load NOP into IF/ID at next edge.
- FlushE  out  1  load bubble (all control zero) into ID/EX at next edge.
- halt_out  out  1  CPU terminated; sticky.
- stall_cnt  out  CNT_W  cycles with StallD=1.
- flush_cnt  out  CNT_W  cycles with FlushD=1 or FlushE=1.

Behaviour:
- Reset (async, RST_n=0): state=RUN, drain counter=0, halt_out=0, stall_cnt=0, flush_cnt=0. While reset is asserted, StallF=StallD=FlushD=FlushE=0. Reset mid-drain or after halt returns to RUN immediately.
- FSM states are RUN, DRAIN, HALTED.
- raw_hit: raw_hit=1 when, for any stage X in {E,M,W}, RegWriteX=1, write_reg_X!=0, and write_reg_X equals rs_addr_D with use_rs_D=1, or equals rt_addr_D with use_rt_D=1. Register $0 never causes a hit.
- Output priority in RUN, highest first, all combinational from inputs and state:
  1. branch_taken_E=1: FlushD=1, FlushE=1, StallF=0, StallD=0. Redirect wins over stall, jump and halt; a halt in ID is squashed and not accepted.
  2. raw_hit=1: StallF=1, StallD=1, FlushE=1, FlushD=0.
  3. halt_D=1: accept. Next state is DRAIN, counter loads DRAIN_CYCLES-1. This cycle: StallF=1, StallD=1, FlushE=1.
  4. JumpD=1: FlushD=1. Other outputs 0.
  5. Otherwise all four outputs are 0.
- DRAIN state:
  - StallF=1, StallD=1, FlushE=1, FlushD=0 every cycle. branch_taken_E is ignored because no branch can be in EX.
  - Counter decrements each cycle. At counter==0 the next state is HALTED.
- HALTED state: halt_out=1 (registered, first asserted on the edge entering HALTED). StallF=StallD=FlushE=1. Stays until reset.
- halt_out latency: DRAIN_CYCLES+1 rising edges after the edge on which halt_D is first sampled with no higher-priority condition active.
- Counters: stall_cnt increments on each edge with StallD=1; flush_cnt increments on each edge with FlushD|FlushE=1. Both saturate at all-ones and do not wrap. They count in every state, HALTED included.
- All state updates occur on the rising edge of CLK.

Test Plan:
- RAW stall: add $3 in EX (RegWriteE=1, write_reg_E=3), ID reads rs=3 with use_rs_D=1 -> StallF=StallD=FlushE=1. Hazard advances EX->M->W, giving 3 stall cycles; stall_cnt=3 after it clears.
- $0 and unused fields: write_reg_E=0 with RegWriteE=1, rs_addr_D=0 -> no stall. write_reg_M=5 with rt_addr_D=5 and use_rt_D=0 -> no stall.
- Branch beats stall: branch_taken_E=1 and raw_hit=1 in the same cycle -> FlushD=FlushE=1, StallF=StallD=0; flush_cnt increments by 1.
- Halt drain: halt_D=1 in RUN with no hazard -> DRAIN for 4 cycles; halt_out rises on the 5th edge after acceptance and remains 1. Outputs stay stalled/flushed in HALTED.
- Squashed halt: halt_D=1 with branch_taken_E=1 -> state stays RUN, halt_out stays 0. Jump in ID -> FlushD=1 for exactly one cycle.
- Async reset mid-DRAIN: drop RST_n between clock edges -> halt_out=0, counters=0, state=RUN immediately without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The master modport is the datapath side; the slave modport is the controller.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
) ();
    logic [4:0]       rs_addr_D;
    logic [4:0]       rt_addr_D;
    logic             use_rs_D;
    logic             use_rt_D;
    logic             JumpD;
    logic             halt_D;
    logic             RegWriteE;
    logic             RegWriteM;
    logic             RegWriteW;
    logic [4:0]       write_reg_E;
    logic [4:0]       write_reg_M;
    logic [4:0]       write_reg_W;
    logic             branch_taken_E;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic             halt_out;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       dbg_state;

    modport master (
        output rs_addr_D, rt_addr_D, use_rs_D, use_rt_D, JumpD, halt_D,
        output RegWriteE, RegWriteM, RegWriteW,
        output write_reg_E, write_reg_M, write_reg_W, branch_taken_E,
        input  StallF, StallD, FlushD, FlushE, halt_out,
        input  stall_cnt, flush_cnt, dbg_state
    );

    modport slave (
        input  rs_addr_D, rt_addr_D, use_rs_D, use_rt_D, JumpD, halt_D,
        input  RegWriteE, RegWriteM, RegWriteW,
        input  write_reg_E, write_reg_M, write_reg_W, branch_taken_E,
        output StallF, StallD, FlushD, FlushE, halt_out,
        output stall_cnt, flush_cnt, dbg_state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage pipeline: RAW stalls, redirect
// flushes, a halt drain FSM and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic          CLK,
    input  logic          RST_n,
    hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic             halt_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             stall_f, stall_d, flush_d, flush_e;
    logic             raw_hit;

    // A stage hits when it writes a nonzero register that ID actually reads.
    function automatic logic stage_hit(input logic we, input logic [4:0] wr);
        return we && (wr != 5'd0) &&
               ((hz.use_rs_D && (wr == hz.rs_addr_D)) ||
                (hz.use_rt_D && (wr == hz.rt_addr_D)));
    endfunction

    assign raw_hit = stage_hit(hz.RegWriteE, hz.write_reg_E) ||
                     stage_hit(hz.RegWriteM, hz.write_reg_M) ||
                     stage_hit(hz.RegWriteW, hz.write_reg_W);

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        case (state_q)
            RUN: begin
                if (hz.branch_taken_E) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (raw_hit) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end else if (hz.halt_D) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                    state_d = DRAIN;
                    drain_d = 4'(DRAIN_CYCLES - 1);
                end else if (hz.JumpD) begin
                    flush_d = 1'b1;
                end
            end
            DRAIN: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
                if (drain_q == 4'd0) state_d = HALTED;
                else                 drain_d = drain_q - 4'd1;
            end
            HALTED: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= RUN;
            drain_q     <= 4'd0;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            halt_q  <= (state_d == HALTED);
            if (stall_d && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if ((flush_d || flush_e) && (flush_cnt_q != {CNT_W{1'b1}}))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    // Control outputs are forced quiet while reset is held, whatever the inputs.
    assign hz.StallF    = RST_n & stall_f;
    assign hz.StallD    = RST_n & stall_d;
    assign hz.FlushD    = RST_n & flush_d;
    assign hz.FlushE    = RST_n & flush_e;
    assign hz.halt_out  = halt_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
    assign hz.dbg_state = state_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stalls, flushes, halt drain and async reset.
module tb_hazard_ctrl;
    logic CLK;
    logic RST_n;
    int   tests_run;
    int   tests_failed;

    hazard_ctrl_if #(.CNT_W(32)) hz ();

    hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .hz    (hz.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed as {StallF, StallD, FlushD, FlushE}.
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {60'd0, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE}, {60'd0, exp});
    endtask

    task automatic chk_cnt(input string tag, input int s, input int f);
        chk({tag, "_stall_cnt"}, {32'd0, hz.stall_cnt}, 64'(s));
        chk({tag, "_flush_cnt"}, {32'd0, hz.flush_cnt}, 64'(f));
    endtask

    task automatic clear_inputs();
        hz.rs_addr_D = 5'd0;  hz.rt_addr_D = 5'd0;
        hz.use_rs_D = 1'b0;   hz.use_rt_D = 1'b0;
        hz.JumpD = 1'b0;      hz.halt_D = 1'b0;
        hz.RegWriteE = 1'b0;  hz.RegWriteM = 1'b0;  hz.RegWriteW = 1'b0;
        hz.write_reg_E = 5'd0; hz.write_reg_M = 5'd0; hz.write_reg_W = 5'd0;
        hz.branch_taken_E = 1'b0;
    endtask

    // Advance one rising edge, then step off it before touching inputs.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        clear_inputs();
        #12;
        @(negedge CLK);
        RST_n = 1'b1;
        step();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        RST_n = 1'b0;
        clear_inputs();

        // Reset: a live hazard on the inputs must not leak through.
        hz.RegWriteE = 1'b1; hz.write_reg_E = 5'd3; hz.rs_addr_D = 5'd3; hz.use_rs_D = 1'b1;
        #12;
        chk_ctl("reset_ctl", 4'b0000);
        chk("reset_halt", {63'd0, hz.halt_out}, 64'd0);
        chk("reset_state", {62'd0, hz.dbg_state}, 64'd0);
        chk_cnt("reset", 0, 0);
        clear_inputs();
        @(negedge CLK);
        RST_n = 1'b1;
        step();

        // Register $0 never hits; unused rt field never hits.
        hz.RegWriteE = 1'b1; hz.write_reg_E = 5'd0; hz.rs_addr_D = 5'd0; hz.use_rs_D = 1'b1;
        settle();
        chk_ctl("zero_reg", 4'b0000);
        clear_inputs();
        hz.RegWriteM = 1'b1; hz.write_reg_M = 5'd5; hz.rt_addr_D = 5'd5; hz.use_rt_D = 1'b0;
        settle();
        chk_ctl("unused_rt", 4'b0000);
        step();
        chk_cnt("no_hazard", 0, 0);

        // RAW on $3 walks EX -> MEM -> WB: three stall cycles.
        clear_inputs();
        hz.rs_addr_D = 5'd3; hz.use_rs_D = 1'b1;
        hz.RegWriteE = 1'b1; hz.write_reg_E = 5'd3;
        settle();
        chk_ctl("raw_ex", 4'b1101);
        step();
        hz.RegWriteE = 1'b0; hz.write_reg_E = 5'd0;
        hz.RegWriteM = 1'b1; hz.write_reg_M = 5'd3;
        settle();
        chk_ctl("raw_mem", 4'b1101);
        step();
        hz.RegWriteM = 1'b0; hz.write_reg_M = 5'd0;
        hz.RegWriteW = 1'b1; hz.write_reg_W = 5'd3;
        settle();
        chk_ctl("raw_wb", 4'b1101);
        step();
        hz.RegWriteW = 1'b0; hz.write_reg_W = 5'd0;
        settle();
        chk_ctl("raw_clear", 4'b0000);
        chk_cnt("raw", 3, 3);

        // Branch redirect beats a concurrent RAW stall.
        clear_inputs();
        hz.RegWriteM = 1'b1; hz.write_reg_M = 5'd7; hz.rt_addr_D = 5'd7; hz.use_rt_D = 1'b1;
        hz.branch_taken_E = 1'b1;
        settle();
        chk_ctl("branch_vs_raw", 4'b0011);
        step();
        chk_cnt("branch", 3, 4);

        // Halt in ID squashed by a taken branch.
        clear_inputs();
        hz.halt_D = 1'b1; hz.branch_taken_E = 1'b1;
        settle();
        chk_ctl("squash_halt", 4'b0011);
        step();
        chk("squash_state", {62'd0, hz.dbg_state}, 64'd0);
        chk("squash_halt_out", {63'd0, hz.halt_out}, 64'd0);

        // Jump flushes IF/ID for exactly one cycle.
        clear_inputs();
        hz.JumpD = 1'b1;
        settle();
        chk_ctl("jump", 4'b0010);
        step();
        clear_inputs();
        settle();
        chk_ctl("jump_after", 4'b0000);
        chk_cnt("jump", 3, 6);

        // Halt acceptance and drain: halt_out rises on the 5th edge.
        hz.halt_D = 1'b1;
        settle();
        chk_ctl("halt_accept", 4'b1101);
        step();
        clear_inputs();
        hz.branch_taken_E = 1'b1;
        settle();
        chk("drain_state", {62'd0, hz.dbg_state}, 64'd1);
        chk_ctl("drain_ctl_branch_ignored", 4'b1101);
        chk("drain_halt_e1", {63'd0, hz.halt_out}, 64'd0);
        step();
        chk("drain_halt_e2", {63'd0, hz.halt_out}, 64'd0);
        step();
        chk("drain_halt_e3", {63'd0, hz.halt_out}, 64'd0);
        step();
        chk("drain_halt_e4", {63'd0, hz.halt_out}, 64'd0);
        chk("drain_state_e4", {62'd0, hz.dbg_state}, 64'd1);
        step();
        chk("halt_out_e5", {63'd0, hz.halt_out}, 64'd1);
        chk("halted_state", {62'd0, hz.dbg_state}, 64'd2);
        chk_cnt("halt_e5", 8, 11);
        step();
        chk("halt_sticky", {63'd0, hz.halt_out}, 64'd1);
        chk_ctl("halted_ctl", 4'b1101);
        chk_cnt("halted", 9, 12);

        // Reset from HALTED, then reset asynchronously mid-drain.
        do_reset();
        chk("post_reset_halt", {63'd0, hz.halt_out}, 64'd0);
        chk_cnt("post_reset", 0, 0);
        hz.halt_D = 1'b1;
        step();
        hz.halt_D = 1'b0;
        step();
        chk("mid_drain_state", {62'd0, hz.dbg_state}, 64'd1);
        #2;
        RST_n = 1'b0;
        #1;
        chk("async_state", {62'd0, hz.dbg_state}, 64'd0);
        chk("async_halt", {63'd0, hz.halt_out}, 64'd0);
        chk_ctl("async_ctl", 4'b0000);
        chk_cnt("async", 0, 0);
        @(negedge CLK);
        RST_n = 1'b1;
        step();
        chk("async_after_run", {62'd0, hz.dbg_state}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
